sr_latch_driver: RTL and testbench

Clocked sequencer that drives the active-low S/R inputs of an asynchronous SR latch from a synchronous request handshake. It issues one set or reset pulse of fixed width and guarantees that S and R are never low together. It enforces a minimum both-high gap between pulses. Optionally it reads back Q/Qn to confirm the latch changed state. It sits between synchronous control logic and the `sr_latch` cell as the initiator side of the latch's S/R interface.

---
 rtl/sr_latch_driver.sv | 164 ++++++++++++++++
 tb/tb_sr_latch_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// Sequencer driving the active-low S/R inputs of an asynchronous SR latch from a valid/ready request.
// Optional feature macro: SR_DRV_CHECK_EN adds Q/Qn readback (CHECK state, synchronizer, err timeout).
module sr_latch_driver #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_op,
    output logic S,
    output logic R,
    input  logic Q,
    input  logic Qn,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int CNT_MAX_PG = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_MAX    = (CNT_MAX_PG > TIMEOUT) ? CNT_MAX_PG : TIMEOUT;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_CHECK = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t           state_r;
    logic             op_r;
    logic [CNT_W-1:0] cnt_r;
    logic             s_r;
    logic             r_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             ready_r;

`ifdef SR_DRV_CHECK_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0] sync1_r;
    logic [1:0] sync2_r;
    logic [1:0] expect_s;
    logic       match_s;

    assign expect_s = op_r ? 2'b10 : 2'b01;
    // The first CHECK cycle still holds a sample taken before the pulse ended, so it is skipped.
    assign match_s  = (cnt_r != CNT_ZERO) && (sync2_r == expect_s);

    // Two-flop synchronizer for the asynchronous latch feedback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= {Q, Qn};
            sync2_r <= sync1_r;
        end
    end
`else
    logic unused_fb_s;
    assign unused_fb_s = Q ^ Qn;
`endif

    // Sequencer FSM; every output is a flop so S/R never glitch and never go low together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            op_r    <= 1'b0;
            cnt_r   <= CNT_ZERO;
            s_r     <= 1'b1;
            r_r     <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && ready_r) begin
                        op_r    <= req_op;
                        state_r <= ST_PULSE;
                        cnt_r   <= CNT_ZERO;
                        s_r     <= ~req_op;
                        r_r     <= req_op;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                    end else begin
                        s_r <= 1'b1;
                        r_r <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_r == PULSE_LAST) begin
                        s_r   <= 1'b1;
                        r_r   <= 1'b1;
                        cnt_r <= CNT_ZERO;
`ifdef SR_DRV_CHECK_EN
                        state_r <= ST_CHECK;
`else
                        state_r <= ST_GAP;
                        done_r  <= 1'b1;
`endif
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`ifdef SR_DRV_CHECK_EN
                ST_CHECK: begin
                    if (match_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_GAP;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == TO_LAST) begin
                        err_r   <= 1'b1;
                        state_r <= ST_GAP;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`endif
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    s_r     <= 1'b1;
                    r_r     <= 1'b1;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_r;
    assign S         = s_r;
    assign R         = r_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed, table-driven bench for sr_latch_driver with a behavioural SR latch on Q/Qn.
// Expectations follow SR_DRV_CHECK_EN: feedback checking adds 2 cycles before done.
module tb_sr_latch_driver;

    localparam int PW = 4;
    localparam int GW = 2;
    localparam int TO = 16;
`ifdef SR_DRV_CHECK_EN
    localparam int NV = 5;
    localparam int EXP_GAP = 5;
`else
    localparam int NV = 4;
    localparam int EXP_GAP = 3;
`endif

    typedef struct {
        logic op;
        int   mode;
        int   s_low;
        int   r_low;
        int   done_at;
        int   err_at;
        int   ready_at;
        logic q;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_op = 1'b0;
    logic req_ready, S, R, Q, Qn, busy, done, err;
    logic latch_q = 1'b0;
    int   fb_mode = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[NV];

    sr_latch_driver #(.PULSE_W(PW), .GAP_W(GW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .S(S), .R(R), .Q(Q), .Qn(Qn),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural SR latch; mode 1 = feedback stuck at reset, mode 2 = both tied low
    always @(S or R) begin
        if (!S) latch_q = 1'b1;
        else if (!R) latch_q = 1'b0;
    end
    assign Q  = (fb_mode == 0) ? latch_q : 1'b0;
    assign Qn = (fb_mode == 0) ? ~latch_q : (fb_mode == 1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'b0, req_ready}, 32'd1);
    endtask

    // Issues one request from a negedge with req_ready high; j counts samples after acceptance edge k+j
    task automatic run_op(input logic op, output int s_low, output int r_low, output int both,
                          output int done_at, output int err_at, output int ready_at,
                          output int done_cnt, output int err_cnt);
        s_low = 0; r_low = 0; both = 0; done_cnt = 0; err_cnt = 0;
        done_at = -1; err_at = -1; ready_at = -2;
        req_valid = 1'b1;
        req_op = op;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (!S) s_low++;
            if (!R) r_low++;
            if (!S && !R) both++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (err) begin
                err_cnt++;
                if (err_at < 0) err_at = j;
            end
            if (req_ready) begin
                ready_at = j;
                break;
            end
        end
    endtask

    initial begin
        int s_low, r_low, both, done_at, err_at, ready_at, done_cnt, err_cnt;
        int first_r, last_s;

`ifdef SR_DRV_CHECK_EN
        vecs[0] = '{1'b0, 0, 0, 4, 6, -1, 8, 1'b0};
        vecs[1] = '{1'b1, 0, 4, 0, 6, -1, 8, 1'b1};
        vecs[2] = '{1'b1, 0, 4, 0, 6, -1, 8, 1'b1};
        vecs[3] = '{1'b1, 1, 4, 0, -1, 20, 22, 1'b0};
        vecs[4] = '{1'b0, 1, 0, 4, 6, -1, 8, 1'b0};
`else
        vecs[0] = '{1'b0, 0, 0, 4, 4, -1, 6, 1'b0};
        vecs[1] = '{1'b1, 0, 4, 0, 4, -1, 6, 1'b1};
        vecs[2] = '{1'b1, 2, 4, 0, 4, -1, 6, 1'b0};
        vecs[3] = '{1'b0, 2, 0, 4, 4, -1, 6, 1'b0};
`endif

        // Reset held with a pending set request
        req_valid = 1'b1;
        req_op = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_S", {31'b0, S}, 32'd1);
            check("rst_R", {31'b0, R}, 32'd1);
            check("rst_busy_done_err", {29'b0, busy, done, err}, 32'd0);
            check("rst_ready", {31'b0, req_ready}, 32'd1);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_accept_busy", {31'b0, busy}, 32'd1);
        check("post_rst_accept_S", {30'b0, S, R}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        wait_ready();

        // Single operations from the vector table
        for (int i = 0; i < NV; i++) begin
            fb_mode = vecs[i].mode;
            run_op(vecs[i].op, s_low, r_low, both, done_at, err_at, ready_at, done_cnt, err_cnt);
            check($sformatf("v%0d_s_low", i), s_low, vecs[i].s_low);
            check($sformatf("v%0d_r_low", i), r_low, vecs[i].r_low);
            check($sformatf("v%0d_both_low", i), both, 0);
            check($sformatf("v%0d_done_at", i), done_at, vecs[i].done_at);
            check($sformatf("v%0d_done_cnt", i), done_cnt, (vecs[i].done_at >= 0) ? 1 : 0);
            check($sformatf("v%0d_err_at", i), err_at, vecs[i].err_at);
            check($sformatf("v%0d_err_cnt", i), err_cnt, (vecs[i].err_at >= 0) ? 1 : 0);
            check($sformatf("v%0d_ready_at", i), ready_at, vecs[i].ready_at);
            check($sformatf("v%0d_q", i), {31'b0, Q}, {31'b0, vecs[i].q});
        end

        // Back-to-back: req_valid held high, set then reset
        fb_mode = 0;
        s_low = 0; r_low = 0; both = 0; first_r = -1; last_s = -1;
        req_valid = 1'b1;
        req_op = 1'b1;
        @(posedge clk);
        #1 req_op = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (!S) begin
                s_low++;
                last_s = j;
            end
            if (!R) begin
                r_low++;
                if (first_r < 0) first_r = j;
                req_valid = 1'b0;
            end
            if (!S && !R) both++;
        end
        req_valid = 1'b0;
        check("b2b_s_low", s_low, PW);
        check("b2b_r_low", r_low, PW);
        check("b2b_both_low", both, 0);
        check("b2b_gap", first_r - last_s - 1, EXP_GAP);
        check("b2b_final_q", {31'b0, Q}, 32'd0);
        check("b2b_idle", {31'b0, req_ready}, 32'd1);

        // Asynchronous reset two cycles into an S pulse
        req_valid = 1'b1;
        req_op = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("mid_S_low_before_rst", {31'b0, S}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_S", {31'b0, S}, 32'd1);
        check("mid_rst_R", {31'b0, R}, 32'd1);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0; err_cnt = 0; s_low = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (!S) s_low++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_no_err", err_cnt, 0);
        check("abort_no_pulse", s_low, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
